// File: rtl/mat_vec_mac_seq.sv
// Sequential matrix-vector MAC engine: y[i] = act(sat((mat*vec + bias<<FRAC) >>> FRAC)), streamed out on valid/ready.
// Define MAT_VEC_RELU_EN to use a ReLU activation; otherwise the saturated result passes through unchanged.
module mat_vec_mac_seq #(
    parameter int N     = 16,
    parameter int W     = 16,
    parameter int LANES = 1,
    parameter int FRAC  = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    input  logic signed [W-1:0]    mat [N][N],
    input  logic signed [W-1:0]    vec [N],
    input  logic signed [W-1:0]    bias [N],
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(N)-1:0]   out_idx,
    output logic signed [W-1:0]    out_data,
    output logic                   done
);

    localparam int IW    = $clog2(N);
    localparam int ACC_W = 2 * W + IW + 1;

    localparam logic [IW-1:0] LAST_COL  = IW'(N - 1);
    localparam logic [IW-1:0] LAST_BASE = IW'(N - LANES);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, FIN, DRAIN} state_t;

    state_t                    state;
    logic [IW-1:0]             row_base;
    logic [IW-1:0]             col;
    logic signed [W-1:0]       vec_r  [N];
    logic signed [W-1:0]       bias_r [N];
    logic signed [W-1:0]       res    [N];
    logic signed [ACC_W-1:0]   acc    [LANES];

    logic [IW-1:0]             lane_row [LANES];
    logic signed [2*W-1:0]     prod     [LANES];
    logic signed [ACC_W-1:0]   biased   [LANES];
    logic signed [ACC_W-1:0]   shifted  [LANES];
    logic signed [W-1:0]       sat      [LANES];
    logic signed [W-1:0]       act      [LANES];

    // Per-lane datapath: product for the current column, and the finished row value used in FIN.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_row[l] = row_base + IW'(l);
            prod[l]     = (2*W)'(mat[lane_row[l]][col]) * (2*W)'(vec_r[col]);
            biased[l]   = acc[l] + (ACC_W'(bias_r[lane_row[l]]) <<< FRAC);
            shifted[l]  = biased[l] >>> FRAC;
            if (shifted[l] > SAT_MAX) begin
                sat[l] = SAT_MAX[W-1:0];
            end else if (shifted[l] < SAT_MIN) begin
                sat[l] = SAT_MIN[W-1:0];
            end else begin
                sat[l] = shifted[l][W-1:0];
            end
`ifdef MAT_VEC_RELU_EN
            act[l] = sat[l][W-1] ? '0 : sat[l];
`else
            act[l] = sat[l];
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            out_idx   <= '0;
            out_data  <= '0;
            row_base  <= '0;
            col       <= '0;
            for (int i = 0; i < N; i++) begin
                vec_r[i]  <= '0;
                bias_r[i] <= '0;
                res[i]    <= '0;
            end
            for (int l = 0; l < LANES; l++) begin
                acc[l] <= '0;
            end
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < N; i++) begin
                            vec_r[i]  <= vec[i];
                            bias_r[i] <= bias[i];
                        end
                        for (int l = 0; l < LANES; l++) begin
                            acc[l] <= '0;
                        end
                        row_base <= '0;
                        col      <= '0;
                        busy     <= 1'b1;
                        state    <= MAC;
                    end
                end
                MAC: begin
                    for (int l = 0; l < LANES; l++) begin
                        acc[l] <= acc[l] + ACC_W'(prod[l]);
                    end
                    if (col == LAST_COL) begin
                        col   <= '0;
                        state <= FIN;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
                FIN: begin
                    for (int l = 0; l < LANES; l++) begin
                        res[lane_row[l]] <= act[l];
                        acc[l]           <= '0;
                    end
                    if (row_base == LAST_BASE) begin
                        row_base <= '0;
                        state    <= DRAIN;
                    end else begin
                        row_base <= row_base + IW'(LANES);
                        state    <= MAC;
                    end
                end
                DRAIN: begin
                    // First DRAIN cycle only loads the output register; handshakes start after that.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_idx   <= '0;
                        out_data  <= res[0];
                    end else if (out_ready) begin
                        if (out_idx == LAST_COL) begin
                            out_valid <= 1'b0;
                            out_idx   <= '0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            out_idx  <= out_idx + 1'b1;
                            out_data <= res[out_idx + 1'b1];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mat_vec_mac_seq.sv
// Directed self-checking bench for mat_vec_mac_seq: an N=4/LANES=1/FRAC=0 instance and an N=4/LANES=2/FRAC=8 instance.
module tb_mat_vec_mac_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    logic               start, out_ready, busy, out_valid, done;
    logic [1:0]         out_idx;
    logic [15:0]        out_data;
    logic signed [15:0] mat [4][4];
    logic signed [15:0] vec [4];
    logic signed [15:0] bias [4];

    logic               start6, out_ready6, busy6, out_valid6, done6;
    logic [1:0]         out_idx6;
    logic [15:0]        out_data6;
    logic signed [15:0] mat6 [4][4];
    logic signed [15:0] vec6 [4];
    logic signed [15:0] bias6 [4];

    int check_count = 0;
    int error_count = 0;
    int done_count  = 0;

    logic [15:0] exp1 [4];
    logic [15:0] exp_all [4];

    mat_vec_mac_seq #(.N(4), .W(16), .LANES(1), .FRAC(0)) u_dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy),
        .mat(mat), .vec(vec), .bias(bias),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_idx(out_idx), .out_data(out_data), .done(done)
    );

    mat_vec_mac_seq #(.N(4), .W(16), .LANES(2), .FRAC(8)) u_dut6 (
        .clk(clk), .rst(rst), .start(start6), .busy(busy6),
        .mat(mat6), .vec(vec6), .bias(bias6),
        .out_valid(out_valid6), .out_ready(out_ready6),
        .out_idx(out_idx6), .out_data(out_data6), .done(done6)
    );

    // Counts every cycle in which the main instance reports done.
    always @(posedge clk) begin
        if (done) done_count <= done_count + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
        check_count++;
        if (got !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, expected);
        end
    endtask

    task automatic applyStimulus(input int kind);
        for (int i = 0; i < 4; i++) begin
            bias[i] = 16'sh0000;
            for (int j = 0; j < 4; j++) begin
                case (kind)
                    0:       mat[i][j] = (i == j) ? 16'sh0001 : 16'sh0000;
                    1:       mat[i][j] = -16'sh0001;
                    2:       mat[i][j] = 16'sh7FFF;
                    default: mat[i][j] = 16'sh8000;
                endcase
            end
            case (kind)
                0:       vec[i] = 16'(i + 1);
                1:       vec[i] = 16'sh0001;
                default: vec[i] = 16'sh7FFF;
            endcase
        end
    endtask

    // Called at a negedge; pulses start and measures cycles from the accepting edge to out_valid.
    task automatic startJob(input int exp_lat, input string tag);
        int cyc = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
        while (!out_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    endtask

    task automatic drainResults(input logic [15:0] expv [4], input int stall_idx,
                                input bit final_start, input string tag);
        int idx    = 0;
        int guard  = 0;
        int stalls = 0;
        int d0     = done_count;
        while (idx < 4 && guard < 100) begin
            if (out_valid) begin
                checkOutput($sformatf("%s_idx%0d", tag, idx), 32'(out_idx), 32'(idx));
                checkOutput($sformatf("%s_data%0d", tag, idx), 32'(out_data), 32'(expv[idx]));
                if (idx == stall_idx && stalls < 3) begin
                    out_ready = 1'b0;
                    start     = 1'b1;
                    stalls++;
                end else begin
                    out_ready = 1'b1;
                    start     = (idx == 3) ? final_start : 1'b0;
                    idx++;
                end
            end else begin
                out_ready = 1'b1;
                start     = 1'b0;
                guard++;
            end
            @(negedge clk);
        end
        start     = 1'b0;
        out_ready = 1'b1;
        checkOutput({tag, "_drained"}, 32'(idx), 32'd4);
        checkOutput({tag, "_done_pulse"}, 32'(done), 32'd1);
        checkOutput({tag, "_busy_low"}, 32'(busy), 32'd0);
        checkOutput({tag, "_valid_low"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        checkOutput({tag, "_done_clear"}, 32'(done), 32'd0);
        checkOutput({tag, "_still_idle"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done_count"}, 32'(done_count - d0), 32'd1);
    endtask

    initial begin
        int cyc;
        int d0;

        start      = 1'b0;
        out_ready  = 1'b1;
        start6     = 1'b0;
        out_ready6 = 1'b1;
        applyStimulus(0);
        for (int i = 0; i < 4; i++) begin
            vec6[i]  = 16'sh0180;
            bias6[i] = 16'sh0080;
            for (int j = 0; j < 4; j++) begin
                mat6[i][j] = (i == j) ? 16'sh0100 : 16'sh0000;
            end
        end
        exp1 = '{16'd1, 16'd2, 16'd3, 16'd4};

        // Reset state
        #12;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_idx", 32'(out_idx), 32'd0);
        checkOutput("rst_data", 32'(out_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Identity matrix
        applyStimulus(0);
        startJob(21, "t1");
        drainResults(exp1, -1, 1'b0, "t1");

        // All -1 matrix
        applyStimulus(1);
`ifdef MAT_VEC_RELU_EN
        exp_all = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
`else
        exp_all = '{16'hFFFC, 16'hFFFC, 16'hFFFC, 16'hFFFC};
`endif
        startJob(21, "t2");
        drainResults(exp_all, -1, 1'b0, "t2");

        // Positive saturation
        applyStimulus(2);
        exp_all = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        startJob(21, "t3a");
        drainResults(exp_all, -1, 1'b0, "t3a");

        // Negative saturation
        applyStimulus(3);
`ifdef MAT_VEC_RELU_EN
        exp_all = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
`else
        exp_all = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
`endif
        startJob(21, "t3b");
        drainResults(exp_all, -1, 1'b0, "t3b");

        // Backpressure at idx 1, start pulses while busy and with the final handshake
        applyStimulus(0);
        startJob(21, "t4");
        drainResults(exp1, 1, 1'b1, "t4");

        // Reset in the middle of the third row's MAC phase
        applyStimulus(0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        checkOutput("t5_busy_before", 32'(busy), 32'd1);
        d0 = done_count;
        #2 rst = 1'b1;
        #1;
        checkOutput("t5_busy_async", 32'(busy), 32'd0);
        checkOutput("t5_valid_async", 32'(out_valid), 32'd0);
        #1 rst = 1'b0;
        repeat (30) @(negedge clk);
        checkOutput("t5_no_done", 32'(done_count - d0), 32'd0);
        checkOutput("t5_idle", 32'(busy), 32'd0);
        startJob(21, "t5");
        drainResults(exp1, -1, 1'b0, "t5");

        // FRAC=8, LANES=2 instance
        start6 = 1'b1;
        @(negedge clk);
        start6 = 1'b0;
        cyc = 0;
        while (!out_valid6 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("t6_latency", 32'(cyc), 32'd11);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("t6_valid%0d", k), 32'(out_valid6), 32'd1);
            checkOutput($sformatf("t6_idx%0d", k), 32'(out_idx6), 32'(k));
            checkOutput($sformatf("t6_data%0d", k), 32'(out_data6), 32'h0200);
            @(negedge clk);
        end
        checkOutput("t6_done", 32'(done6), 32'd1);
        checkOutput("t6_busy_low", 32'(busy6), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
